// File: rtl/mux4_1_rr_arb_if.sv
// mux4_1_rr_arb_if: four valid/ready source channels merged onto one tagged output stream
interface mux4_1_rr_arb_if #(parameter int DW = 8);
  logic [3:0]      in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_sel;
  logic            out_ready;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_sel);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sel);
endinterface

// File: rtl/mux4_1_rr_arb.sv
// mux4_1_rr_arb: round-robin 4:1 merge with one registered output stage carrying the source index
module mux4_1_rr_arb #(parameter int DW = 8) (
  input logic            clk,
  input logic            rst_n,
  mux4_1_rr_arb_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t        state, state_nxt;
  logic [1:0]    ptr, ptr_nxt, g, idx, sel_q, sel_nxt;
  logic [DW-1:0] data_q, data_nxt;
  logic          gv, ld;
  // downward scan so the lowest offset from ptr wins
  always_comb begin
    g = ptr;
    gv = 1'b0;
    idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (bus.in_valid[idx]) begin
        g = idx;
        gv = 1'b1;
      end
    end
  end
  assign ld = (state == EMPTY) | bus.out_ready;
  assign bus.in_ready = (rst_n & ld & gv) ? 4'b0001 << g : 4'b0000;
  always_comb begin
    state_nxt = state;
    ptr_nxt = ptr;
    data_nxt = data_q;
    sel_nxt = sel_q;
    if (ld) begin
      state_nxt = gv ? FULL : EMPTY;
      if (gv) begin
        data_nxt = bus.in_data[g*DW +: DW];
        sel_nxt = g;
        ptr_nxt = g + 2'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      ptr <= '0;
      data_q <= '0;
      sel_q <= '0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      data_q <= data_nxt;
      sel_q <= sel_nxt;
    end
  end
  assign bus.out_valid = (state == FULL);
  assign bus.out_data = data_q;
  assign bus.out_sel = sel_q;
endmodule
